// File: rtl/axilite4_pkg.sv
// Shared definitions for the AXI Lite 4 address decoders.
// Holds bus widths, the target-select encoding, the read FSM state
// encoding and the address-window decode helper.
package axilite4_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 128;

    typedef enum logic [1:0] {
        TGT_S0   = 2'd0,
        TGT_S1   = 2'd1,
        TGT_NONE = 2'd2
    } tgt_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        ERR  = 2'd3
    } rdState_t;

    // Slave 0 is tested first, so it wins when both windows overlap.
    function automatic tgt_t decodeAddr(
        input logic [ADDR_W-1:0] addr, s0Base, s0Mask, s1Base, s1Mask
    );
        if ((addr & s0Mask) == s0Base) return TGT_S0;
        if ((addr & s1Mask) == s1Base) return TGT_S1;
        return TGT_NONE;
    endfunction

endpackage

// File: rtl/axilite4_watchdog.sv
// Per-transaction watchdog timer shared by the read and write decoders.
// Ports:
//   clk    - clock, posedge
//   rst    - asynchronous active-low reset
//   clear  - forces the timer to zero (takes priority over enable)
//   enable - timer counts up by one each cycle while high
//   expire - high in the cycle the timer reaches TIMEOUT-1 while enabled;
//            never asserted when TIMEOUT is 0
module axilite4_watchdog #(
    parameter int TIMEOUT = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam bit          ENABLED = (TIMEOUT != 0);
    localparam logic [15:0] LIMIT   = ENABLED ? 16'(TIMEOUT - 1) : 16'd0;

    logic [15:0] timer;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timer <= 16'd0;
        end else if (clear) begin
            timer <= 16'd0;
        end else if (enable) begin
            timer <= timer + 16'd1;
        end
    end

    assign expire = ENABLED && enable && (timer == LIMIT);

endmodule

// File: rtl/axilite4_read_decoder.sv
// AXI Lite 4 read-channel router: one master, two slaves selected by
// address window. Unmapped addresses get a local error response
// (ERR_DATA); a watchdog turns a silent slave into an error response and
// the late data that slave eventually returns is drained and discarded.
// Ports:
//   clk, rst                 - clock (posedge), asynchronous active-low reset
//   m_readAddr_*             - master read-address channel (addr/valid in, ready out)
//   m_readData_*             - master read-data channel (data/valid out, ready in)
//   s0_readAddr_*, s1_...    - slave read-address channels (addr/valid out, ready in)
//   s0_readData_*, s1_...    - slave read-data channels (data/valid in, ready out)
//   err_count                - saturating count of error responses delivered
// All channel outputs are combinational; unselected outputs are driven 0.
module axilite4_read_decoder
    import axilite4_pkg::*;
#(
    parameter logic [ADDR_W-1:0] S0_BASE  = 32'h0000_0000,
    parameter logic [ADDR_W-1:0] S0_MASK  = 32'hFFFF_0000,
    parameter logic [ADDR_W-1:0] S1_BASE  = 32'h1000_0000,
    parameter logic [ADDR_W-1:0] S1_MASK  = 32'hF000_0000,
    parameter int                TIMEOUT  = 256,
    parameter logic [DATA_W-1:0] ERR_DATA = 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] m_readAddr_addr,
    input  logic              m_readAddr_valid,
    output logic              m_readAddr_ready,
    output logic [DATA_W-1:0] m_readData_data,
    output logic              m_readData_valid,
    input  logic              m_readData_ready,
    output logic [ADDR_W-1:0] s0_readAddr_addr,
    output logic              s0_readAddr_valid,
    input  logic              s0_readAddr_ready,
    input  logic [DATA_W-1:0] s0_readData_data,
    input  logic              s0_readData_valid,
    output logic              s0_readData_ready,
    output logic [ADDR_W-1:0] s1_readAddr_addr,
    output logic              s1_readAddr_valid,
    input  logic              s1_readAddr_ready,
    input  logic [DATA_W-1:0] s1_readData_data,
    input  logic              s1_readData_valid,
    output logic              s1_readData_ready,
    output logic [15:0]       err_count
);

    rdState_t    state;
    tgt_t        tgt;
    tgt_t        decTgt;
    logic [1:0]  drain;
    logic [15:0] errCount;
    logic        expire;
    logic        selAddrReady;
    logic        selDataValid;
    logic        decBlocked;

    // The master holds the address stable while valid, so it is decoded
    // live rather than registered.
    assign decTgt = decodeAddr(m_readAddr_addr, S0_BASE, S0_MASK, S1_BASE, S1_MASK);

    // A slave still owing late data cannot take a new request until that
    // data has been drained.
    assign decBlocked = (decTgt != TGT_NONE) && drain[decTgt[0]];

    assign selAddrReady = (tgt == TGT_S1) ? s1_readAddr_ready : s0_readAddr_ready;
    assign selDataValid = (tgt == TGT_S1) ? s1_readData_valid : s0_readData_valid;
    assign err_count    = errCount;

    axilite4_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) watchdog (
        .clk   (clk),
        .rst   (rst),
        .clear (state != DATA),
        .enable(state == DATA),
        .expire(expire)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            tgt      <= TGT_S0;
            drain    <= 2'b00;
            errCount <= 16'd0;
        end else begin
            if (drain[0] && s0_readData_valid) drain[0] <= 1'b0;
            if (drain[1] && s1_readData_valid) drain[1] <= 1'b0;

            case (state)
                IDLE: begin
                    if (m_readAddr_valid && !decBlocked) begin
                        tgt   <= decTgt;
                        state <= ADDR;
                    end
                end
                ADDR: begin
                    if (tgt == TGT_NONE) begin
                        state <= ERR;
                    end else if (m_readAddr_valid && selAddrReady) begin
                        state <= DATA;
                    end
                end
                DATA: begin
                    // Data arriving on the expiry cycle still wins.
                    if (selDataValid && m_readData_ready) begin
                        state <= IDLE;
                    end else if (expire && !selDataValid) begin
                        drain[tgt[0]] <= 1'b1;
                        state         <= ERR;
                    end
                end
                ERR: begin
                    if (m_readData_ready) begin
                        if (errCount != 16'hFFFF) errCount <= errCount + 16'd1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        m_readAddr_ready  = 1'b0;
        m_readData_data   = '0;
        m_readData_valid  = 1'b0;
        s0_readAddr_addr  = '0;
        s0_readAddr_valid = 1'b0;
        s1_readAddr_addr  = '0;
        s1_readAddr_valid = 1'b0;
        s0_readData_ready = drain[0];
        s1_readData_ready = drain[1];

        case (state)
            ADDR: begin
                if (tgt == TGT_S0) begin
                    s0_readAddr_addr  = m_readAddr_addr;
                    s0_readAddr_valid = m_readAddr_valid;
                    m_readAddr_ready  = s0_readAddr_ready;
                end else if (tgt == TGT_S1) begin
                    s1_readAddr_addr  = m_readAddr_addr;
                    s1_readAddr_valid = m_readAddr_valid;
                    m_readAddr_ready  = s1_readAddr_ready;
                end else begin
                    m_readAddr_ready = 1'b1;
                end
            end
            DATA: begin
                // The active target is never a draining slave, so the
                // drain-driven ready above is zero here for that slave.
                if (tgt == TGT_S1) begin
                    m_readData_data   = s1_readData_data;
                    m_readData_valid  = s1_readData_valid;
                    s1_readData_ready = m_readData_ready;
                end else begin
                    m_readData_data   = s0_readData_data;
                    m_readData_valid  = s0_readData_valid;
                    s0_readData_ready = m_readData_ready;
                end
            end
            ERR: begin
                m_readData_data  = ERR_DATA;
                m_readData_valid = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_axilite4_read_decoder.sv
module tb_axilite4_read_decoder;

    localparam int           TMO = 8;
    localparam logic [127:0] ERR = 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  m_readAddr_addr;
    logic         m_readAddr_valid;
    logic         m_readAddr_ready;
    logic [127:0] m_readData_data;
    logic         m_readData_valid;
    logic         m_readData_ready;
    logic [31:0]  s0_readAddr_addr;
    logic         s0_readAddr_valid;
    logic         s0_readAddr_ready;
    logic [127:0] s0_readData_data;
    logic         s0_readData_valid;
    logic         s0_readData_ready;
    logic [31:0]  s1_readAddr_addr;
    logic         s1_readAddr_valid;
    logic         s1_readAddr_ready;
    logic [127:0] s1_readData_data;
    logic         s1_readData_valid;
    logic         s1_readData_ready;
    logic [15:0]  err_count;
    logic         anyOut;

    int total = 0;
    int bad   = 0;
    int errModel = 0;

    always #5 clk = ~clk;

    axilite4_read_decoder #(.TIMEOUT(TMO)) dut (
        .clk              (clk),
        .rst              (rst),
        .m_readAddr_addr  (m_readAddr_addr),
        .m_readAddr_valid (m_readAddr_valid),
        .m_readAddr_ready (m_readAddr_ready),
        .m_readData_data  (m_readData_data),
        .m_readData_valid (m_readData_valid),
        .m_readData_ready (m_readData_ready),
        .s0_readAddr_addr (s0_readAddr_addr),
        .s0_readAddr_valid(s0_readAddr_valid),
        .s0_readAddr_ready(s0_readAddr_ready),
        .s0_readData_data (s0_readData_data),
        .s0_readData_valid(s0_readData_valid),
        .s0_readData_ready(s0_readData_ready),
        .s1_readAddr_addr (s1_readAddr_addr),
        .s1_readAddr_valid(s1_readAddr_valid),
        .s1_readAddr_ready(s1_readAddr_ready),
        .s1_readData_data (s1_readData_data),
        .s1_readData_valid(s1_readData_valid),
        .s1_readData_ready(s1_readData_ready),
        .err_count        (err_count)
    );

    assign anyOut = |{m_readAddr_ready, m_readData_data, m_readData_valid,
                      s0_readAddr_addr, s0_readAddr_valid, s0_readData_ready,
                      s1_readAddr_addr, s1_readAddr_valid, s1_readData_ready,
                      err_count};

    typedef struct {
        logic [31:0]  addr;
        int           aDly;
        int           dDly;
        logic [127:0] sData;
        int           expSeen;
        logic [127:0] expData;
        int           expHs;
        int           expDone;
        int           expErr;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic idleInputs();
        m_readAddr_addr   = '0;
        m_readAddr_valid  = 1'b0;
        m_readData_ready  = 1'b0;
        s0_readAddr_ready = 1'b0;
        s0_readData_data  = '0;
        s0_readData_valid = 1'b0;
        s1_readAddr_ready = 1'b0;
        s1_readData_data  = '0;
        s1_readData_valid = 1'b0;
    endtask

    // Master plus both slave models for one read. Cycle 0 is the first
    // cycle the master presents valid. The addressed slave raises
    // addr-ready after aDly cycles of seeing valid and raises data-valid
    // dDly cycles after the address handshake (never when dDly < 0).
    task automatic runRead(input logic [31:0] addr, input int aDly, input int dDly,
                           input logic [127:0] sData, output int seen, output int badAddr,
                           output int hsCyc, output int doneCyc, output logic [127:0] got);
        int cyc, aCnt, dCnt, who;
        bit addrDone, done;
        cyc = 0; aCnt = 0; dCnt = 0; who = -1; addrDone = 0; done = 0;
        seen = 0; badAddr = 0; hsCyc = -1; doneCyc = -1; got = '0;
        while (!done && cyc < 64) begin
            @(posedge clk); #1;
            m_readAddr_addr   = addr;
            m_readAddr_valid  = !addrDone;
            m_readData_ready  = 1'b1;
            s0_readAddr_ready = (aCnt >= aDly);
            s1_readAddr_ready = (aCnt >= aDly);
            s0_readData_data  = (who == 0) ? sData : '0;
            s1_readData_data  = (who == 1) ? sData : '0;
            s0_readData_valid = addrDone && who == 0 && dDly >= 0 && dCnt >= dDly;
            s1_readData_valid = addrDone && who == 1 && dDly >= 0 && dCnt >= dDly;
            @(negedge clk);
            if (s0_readAddr_valid || s0_readData_ready) seen = seen | 1;
            if (s1_readAddr_valid || s1_readData_ready) seen = seen | 2;
            if (s0_readAddr_valid && s0_readAddr_addr !== addr) badAddr++;
            if (s1_readAddr_valid && s1_readAddr_addr !== addr) badAddr++;
            if (addrDone) begin
                dCnt++;
            end else if (m_readAddr_valid && m_readAddr_ready) begin
                addrDone = 1;
                hsCyc    = cyc;
                who      = s0_readAddr_valid ? 0 : (s1_readAddr_valid ? 1 : 2);
            end else if (s0_readAddr_valid || s1_readAddr_valid) begin
                aCnt++;
            end
            if (m_readData_valid && m_readData_ready) begin
                done    = 1;
                doneCyc = cyc;
                got     = m_readData_data;
            end
            cyc++;
        end
    endtask

    task automatic runAndCheck(input string nm, input logic [31:0] addr, input int aDly,
                               input int dDly, input logic [127:0] sData, input int expSeen,
                               input logic [127:0] expData, input int expHs,
                               input int expDone, input int expErr);
        int seen, badAddr, hsCyc, doneCyc;
        logic [127:0] got;
        runRead(addr, aDly, dDly, sData, seen, badAddr, hsCyc, doneCyc, got);
        chk({nm, "_data"}, got, expData);
        chk({nm, "_slaves"}, seen, expSeen);
        chk({nm, "_slvaddr"}, badAddr, 0);
        chk({nm, "_hscycle"}, hsCyc, expHs);
        chk({nm, "_donecycle"}, doneCyc, expDone);
        @(posedge clk); #1;
        idleInputs();
        chk({nm, "_errcnt"}, err_count, expErr);
    endtask

    // Behavioural routing rule from the address windows.
    function automatic int refTgt(input logic [31:0] a);
        if ((a & 32'hFFFF_0000) == 32'h0000_0000) return 0;
        if ((a & 32'hF000_0000) == 32'h1000_0000) return 1;
        return 2;
    endfunction

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{32'h0000_0040, 0, 2, 128'h1234, 1, 128'h1234, 1, 4, 0};
        tbl[1] = '{32'h1000_0000, 3, 0, 128'h5678, 2, 128'h5678, 4, 5, 0};
        tbl[2] = '{32'h2000_0000, 0, 0, 128'h9999, 0, ERR, 1, 2, 1};
        tbl[3] = '{32'h0000_FFFC, 1, 7, 128'hA5A5, 1, 128'hA5A5, 2, 10, 1};
        tbl[4] = '{32'h0000_1000, 0, 0, 128'h1111, 1, 128'h1111, 1, 2, 1};
        tbl[5] = '{32'h1FFF_FFF0, 0, 5, 128'h2222, 2, 128'h2222, 1, 7, 1};
        tbl[6] = '{32'h0001_0000, 0, 0, 128'h3333, 0, ERR, 1, 2, 2};
        tbl[7] = '{32'hFFFF_FFFF, 2, 1, 128'h4444, 0, ERR, 1, 2, 3};

        rst = 1'b0;
        idleInputs();
        #23;
        chk("reset_outputs", anyOut, 0);
        chk("reset_errcnt", err_count, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("idle_outputs", anyOut, 0);

        for (int i = 0; i < 8; i++) begin
            runAndCheck($sformatf("vec%0d", i), tbl[i].addr, tbl[i].aDly, tbl[i].dDly,
                        tbl[i].sData, tbl[i].expSeen, tbl[i].expData, tbl[i].expHs,
                        tbl[i].expDone, tbl[i].expErr);
        end
        errModel = 3;

        // Slave 0 never answers: error after TMO data cycles, drain[0] set.
        errModel++;
        runAndCheck("timeout_s0", 32'h0000_0100, 0, -1, 128'h7777, 1, ERR, 1, 2 + TMO, errModel);
        // Slave 1 is unaffected; slave 0 keeps draining meanwhile.
        runAndCheck("s1_during_drain", 32'h1000_0010, 0, 1, 128'h8888, 3, 128'h8888, 1, 3, errModel);

        // A request to the draining slave waits in IDLE.
        @(posedge clk); #1;
        idleInputs();
        m_readAddr_addr  = 32'h0000_0080;
        m_readAddr_valid = 1'b1;
        m_readData_ready = 1'b1;
        s0_readAddr_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("drain_stall_ardy", m_readAddr_ready, 0);
            chk("drain_stall_s0v", s0_readAddr_valid, 0);
            chk("drain_ready", s0_readData_ready, 1);
            @(posedge clk); #1;
        end
        s0_readData_valid = 1'b1;
        s0_readData_data  = 128'hBAD;
        @(negedge clk);
        chk("late_data_ready", s0_readData_ready, 1);
        chk("late_data_hidden", m_readData_valid, 0);
        @(posedge clk); #1;
        idleInputs();
        @(negedge clk);
        chk("drain_cleared", s0_readData_ready, 0);
        runAndCheck("s0_after_drain", 32'h0000_0080, 0, 0, 128'hABCD, 1, 128'hABCD, 1, 2, errModel);

        for (int i = 0; i < 40; i++) begin
            logic [31:0]  a;
            logic [127:0] d;
            int k, aD, dD, t;
            k  = $urandom_range(0, 3);
            aD = $urandom_range(0, 3);
            dD = $urandom_range(0, TMO - 1);
            d  = {$urandom, $urandom, $urandom, $urandom};
            case (k)
                0: a = {16'h0000, 16'($urandom)};
                1: a = {4'h1, 28'($urandom)};
                2: a = {4'($urandom_range(2, 15)), 28'($urandom)};
                default: a = $urandom;
            endcase
            t = refTgt(a);
            if (t == 2) begin
                errModel++;
                runAndCheck($sformatf("rnd%0d", i), a, aD, dD, d, 0, ERR, 1, 2, errModel);
            end else begin
                runAndCheck($sformatf("rnd%0d", i), a, aD, dD, d, 1 << t, d,
                            1 + aD, 2 + aD + dD, errModel);
            end
        end

        // Reset while a read to slave 0 is in its data phase.
        @(posedge clk); #1;
        idleInputs();
        m_readAddr_addr   = 32'h0000_0040;
        m_readAddr_valid  = 1'b1;
        s0_readAddr_ready = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        m_readAddr_valid  = 1'b0;
        s0_readData_valid = 1'b1;
        s0_readData_data  = 128'hCAFE;
        #1;
        chk("pre_reset_data", m_readData_data, 128'hCAFE);
        chk("pre_reset_errcnt", err_count, errModel);
        rst = 1'b0;
        #1;
        chk("async_reset_outputs", anyOut, 0);
        chk("async_reset_errcnt", err_count, 0);
        idleInputs();
        @(negedge clk);
        rst = 1'b1;
        errModel = 0;
        runAndCheck("after_reset", 32'h0000_0044, 0, 1, 128'hF00D, 1, 128'hF00D, 1, 3, errModel);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
